// File: rtl/safe_lock_ctrl_if.sv
// Code-entry handshake, serial bit stream to the unlock mechanism, and the
// mechanism's Moore status outputs, bundled for safe_lock_ctrl.
interface safe_lock_ctrl_if;
  logic       code_valid;
  logic [3:0] code_data;
  logic       code_ready;
  logic       ser_val;
  logic       ser_data;
  logic       mech_out_val;
  logic       mech_out_data;

  modport master (
    output code_valid, code_data, mech_out_val, mech_out_data,
    input  code_ready, ser_val, ser_data
  );

  modport slave (
    input  code_valid, code_data, mech_out_val, mech_out_data,
    output code_ready, ser_val, ser_data
  );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Safe lock controller: serialises a 4-bit code to the unlock mechanism, tracks
// failures/lockout and resyncs the mechanism. Optional alarm: SAFE_LOCK_ALARM_EN.
module safe_lock_ctrl #(
  parameter int unsigned UNLOCK_CYCLES  = 16,
  parameter int unsigned LOCKOUT_CYCLES = 64,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  safe_lock_ctrl_if.slave        bus,
  output logic                   unlocked,
  output logic                   lockout,
  output logic [1:0]             fail_cnt,
  output logic                   err
`ifdef SAFE_LOCK_ALARM_EN
  ,
  input  logic                   alarm_clr,
  output logic                   alarm
`endif
);

  localparam int unsigned MAX_T     = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                       : LOCKOUT_CYCLES;
  localparam int unsigned TW        = $clog2(MAX_T) + 1;
  localparam int unsigned FW        = 3;
  localparam int unsigned FLUSH_MAX = 4;

  typedef enum logic [2:0] {
    S_FLUSH_CHK, S_FLUSH_TX, S_IDLE, S_SEND, S_EVAL, S_UNLOCK, S_LOCKOUT, S_ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      code_q, code_d;
  logic [1:0]      bit_q, bit_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [1:0]      fail_q, fail_d;
  logic            code_ready_q, code_ready_d;
  logic            ser_val_q, ser_val_d;
  logic            ser_data_q, ser_data_d;
  logic            unlocked_q, unlocked_d;
  logic            lockout_q, lockout_d;
  logic            err_q, err_d;
`ifdef SAFE_LOCK_ALARM_EN
  logic            alarm_q, alarm_d;
`endif

  // Next state plus outputs decoded from the next state, so outputs track state.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    bit_d      = bit_q;
    timer_d    = '0;
    flush_d    = flush_q;
    fail_d     = fail_q;
    ser_data_d = 1'b0;
`ifdef SAFE_LOCK_ALARM_EN
    alarm_d    = alarm_q;
`endif

    case (state_q)
      S_FLUSH_CHK: begin
        if (!bus.mech_out_val) begin
          state_d = S_IDLE;
          flush_d = '0;
        end else if (flush_q == FW'(FLUSH_MAX)) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_FLUSH_TX;
          flush_d = flush_q + FW'(1);
        end
      end
      S_FLUSH_TX: state_d = S_FLUSH_CHK;
      S_IDLE: begin
        if (bus.code_valid) begin
          state_d    = S_SEND;
          code_d     = bus.code_data;
          bit_d      = '0;
          ser_data_d = bus.code_data[3];
        end
      end
      // code_q shifts left so bit [2] always holds the next bit to send.
      S_SEND: begin
        if (bit_q == 2'd3) begin
          state_d = S_EVAL;
        end else begin
          bit_d      = bit_q + 2'd1;
          ser_data_d = code_q[2];
          code_d     = {code_q[2:0], 1'b0};
        end
      end
      S_EVAL: begin
        if (bus.mech_out_data) begin
          state_d = S_UNLOCK;
          fail_d  = '0;
        end else begin
          fail_d  = (fail_q >= 2'(MAX_FAILS)) ? fail_q : fail_q + 2'd1;
          state_d = (fail_d == 2'(MAX_FAILS)) ? S_LOCKOUT : S_FLUSH_CHK;
        end
      end
      S_UNLOCK: begin
        if (timer_q == TW'(UNLOCK_CYCLES - 1)) state_d = S_FLUSH_CHK;
        else                                   timer_d = timer_q + TW'(1);
      end
      S_LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          state_d = S_FLUSH_CHK;
          fail_d  = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

`ifdef SAFE_LOCK_ALARM_EN
    // Set wins over clear; ERROR forces every non-fail_cnt output low.
    if (state_q == S_EVAL && state_d == S_LOCKOUT) alarm_d = 1'b1;
    else if (alarm_clr)                            alarm_d = 1'b0;
    if (state_d == S_ERROR)                        alarm_d = 1'b0;
`endif

    code_ready_d = (state_d == S_IDLE);
    ser_val_d    = (state_d == S_SEND) || (state_d == S_FLUSH_TX);
    unlocked_d   = (state_d == S_UNLOCK);
    lockout_d    = (state_d == S_LOCKOUT);
    err_d        = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FLUSH_CHK;
      code_q       <= '0;
      bit_q        <= '0;
      timer_q      <= '0;
      flush_q      <= '0;
      fail_q       <= '0;
      code_ready_q <= 1'b0;
      ser_val_q    <= 1'b0;
      ser_data_q   <= 1'b0;
      unlocked_q   <= 1'b0;
      lockout_q    <= 1'b0;
      err_q        <= 1'b0;
`ifdef SAFE_LOCK_ALARM_EN
      alarm_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      bit_q        <= bit_d;
      timer_q      <= timer_d;
      flush_q      <= flush_d;
      fail_q       <= fail_d;
      code_ready_q <= code_ready_d;
      ser_val_q    <= ser_val_d;
      ser_data_q   <= ser_data_d;
      unlocked_q   <= unlocked_d;
      lockout_q    <= lockout_d;
      err_q        <= err_d;
`ifdef SAFE_LOCK_ALARM_EN
      alarm_q      <= alarm_d;
`endif
    end
  end

  assign bus.code_ready = code_ready_q;
  assign bus.ser_val    = ser_val_q;
  assign bus.ser_data   = ser_data_q;
  assign unlocked       = unlocked_q;
  assign lockout        = lockout_q;
  assign fail_cnt       = fail_q;
  assign err            = err_q;
`ifdef SAFE_LOCK_ALARM_EN
  assign alarm          = alarm_q;
`endif

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Scoreboard bench for safe_lock_ctrl with a behavioural unlock-mechanism model.
module tb_safe_lock_ctrl;
  localparam logic [3:0] SECRET = 4'b1011;
  localparam int UNL = 16;
  localparam int LCK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       unlocked, lockout, err;
  logic [1:0] fail_cnt;
`ifdef SAFE_LOCK_ALARM_EN
  logic       alarm_clr = 1'b0;
  logic       alarm;
`endif

  safe_lock_ctrl_if bus ();

  safe_lock_ctrl #(.UNLOCK_CYCLES(UNL), .LOCKOUT_CYCLES(LCK), .MAX_FAILS(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt), .err(err)
`ifdef SAFE_LOCK_ALARM_EN
    , .alarm_clr(alarm_clr), .alarm(alarm)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unlock mechanism: shifts in 4 bits, then any further bit returns it to IDLE.
  logic [2:0] m_cnt = '0;
  logic [3:0] m_sh  = '0;
  logic       stuck = 1'b0;
  always @(posedge clk) begin
    if (bus.ser_val) begin
      if (m_cnt == 3'd4) m_cnt <= '0;
      else begin
        m_sh  <= {m_sh[2:0], bus.ser_data};
        m_cnt <= m_cnt + 3'd1;
      end
    end
  end
  assign bus.mech_out_val  = stuck | (m_cnt != 3'd0);
  assign bus.mech_out_data = !stuck && (m_cnt == 3'd4) && (m_sh == SECRET);

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fail = 0;
  int ser_q[$], unl_rise_q[$], unl_len_q[$], lock_len_q[$], fail_q[$], err_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name, input int act);
    n_checks++;
    $display("FAIL %s: unexpected output value %0d with nothing queued (cycle %0d)",
             name, act, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents an observable event.
  initial begin
    int unl_len = 0, lock_len = 0;
    logic unl_prev = 1'b0, lock_prev = 1'b0, err_prev = 1'b0;
    logic [1:0] fail_prev = 2'd0;
    forever begin
      @(negedge clk);
      if (bus.ser_val) begin
        if (ser_q.size() == 0) unexpected("ser_bit", int'(bus.ser_data));
        else chk("ser_bit", int'(bus.ser_data), ser_q.pop_front());
      end
      if (unlocked && !unl_prev) begin
        if (unl_rise_q.size() == 0) unexpected("unlock_rise", cyc);
        else chk("unlock_rise_cycle", cyc, unl_rise_q.pop_front());
      end
      if (unlocked) unl_len++;
      if (!unlocked && unl_prev) begin
        if (unl_len_q.size() == 0) unexpected("unlock_len", unl_len);
        else chk("unlock_len", unl_len, unl_len_q.pop_front());
        unl_len = 0;
      end
      if (lockout) lock_len++;
      if (!lockout && lock_prev) begin
        if (lock_len_q.size() == 0) unexpected("lockout_len", lock_len);
        else chk("lockout_len", lock_len, lock_len_q.pop_front());
        lock_len = 0;
      end
      if (fail_cnt != fail_prev) begin
        if (fail_q.size() == 0) unexpected("fail_cnt", int'(fail_cnt));
        else chk("fail_cnt_step", int'(fail_cnt), fail_q.pop_front());
      end
      if (err && !err_prev) begin
        if (err_q.size() == 0) unexpected("err_rise", 1);
        else chk("err_rise", 1, err_q.pop_front());
      end
      unl_prev  = unlocked;
      lock_prev = lockout;
      fail_prev = fail_cnt;
      err_prev  = err;
    end
  end

  task automatic wait_ready(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (bus.code_ready) break;
    end
    chk("reach_idle_ready", int'(bus.code_ready), 1);
  endtask

  // Issue one code and queue every response the DUT must produce for it.
  task automatic send_code(input logic [3:0] code);
    int t;
    wait_ready(200);
    bus.code_valid = 1'b1;
    bus.code_data  = code;
    t = cyc;
    for (int i = 3; i >= 0; i--) ser_q.push_back(int'(code[i]));
    if (code == SECRET) begin
      unl_rise_q.push_back(t + 6);
      unl_len_q.push_back(UNL);
      if (exp_fail != 0) fail_q.push_back(0);
      exp_fail = 0;
    end else begin
      exp_fail = (exp_fail >= 3) ? 3 : exp_fail + 1;
      fail_q.push_back(exp_fail);
      if (exp_fail == 3) begin
        lock_len_q.push_back(LCK);
        fail_q.push_back(0);
        exp_fail = 0;
      end
    end
    ser_q.push_back(0);
    @(negedge clk);
    bus.code_valid = 1'b0;
    chk("ready_low_after_accept", int'(bus.code_ready), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bus.code_valid = 1'b0;
    bus.code_data  = 4'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_code_ready", int'(bus.code_ready), 0);
    chk("rst_ser_val", int'(bus.ser_val), 0);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_fail_cnt", int'(fail_cnt), 0);
    chk("rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Correct code, wrong code, then fail 1,2 cleared by success.
    send_code(SECRET);
    send_code(4'b0011);
    wait_ready(200);
    chk("fail_after_wrong", int'(fail_cnt), 1);
    chk("unlocked_after_wrong", int'(unlocked), 0);
    send_code(4'b0000);
    send_code(SECRET);
    wait_ready(200);
    chk("fail_after_success", int'(fail_cnt), 0);

    // Three wrong codes -> lockout; code_valid during lockout must be ignored.
    send_code(4'b0111);
    send_code(4'b1111);
    send_code(4'b1010);
    for (int k = 0; k < 50 && !lockout; k++) @(negedge clk);
    chk("lockout_entered", int'(lockout), 1);
    bus.code_valid = 1'b1;
    bus.code_data  = SECRET;
    repeat (5) begin
      @(negedge clk);
      chk("ready_low_in_lockout", int'(bus.code_ready), 0);
    end
    bus.code_valid = 1'b0;
    wait_ready(200);
    chk("fail_after_lockout", int'(fail_cnt), 0);
`ifdef SAFE_LOCK_ALARM_EN
    chk("alarm_held", int'(alarm), 1);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    chk("alarm_cleared", int'(alarm), 0);
`endif

    // Reset during the second SEND bit, then flush resynchronises the mechanism.
    wait_ready(200);
    bus.code_valid = 1'b1;
    bus.code_data  = SECRET;
    ser_q.push_back(1);
    @(posedge clk);
    #1 bus.code_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midsend_rst_ser_val", int'(bus.ser_val), 0);
    chk("midsend_rst_ready", int'(bus.code_ready), 0);
    repeat (4) ser_q.push_back(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ready(200);
    chk("mech_idle_after_flush", int'(bus.mech_out_val), 0);

    // Mechanism stuck busy: four flush bits then ERROR until reset.
    stuck = 1'b1;
    rst   = 1'b1;
    repeat (4) ser_q.push_back(0);
    err_q.push_back(1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 50 && !err; k++) @(negedge clk);
    chk("err_set", int'(err), 1);
    repeat (20) @(negedge clk);
    chk("err_held", int'(err), 1);
    chk("err_ready_low", int'(bus.code_ready), 0);
    chk("err_ser_val_low", int'(bus.ser_val), 0);
    chk("err_unlocked_low", int'(unlocked), 0);
    chk("err_lockout_low", int'(lockout), 0);
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", int'(err), 0);
    stuck = 1'b0;
    ser_q.push_back(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(100);

    repeat (10) @(negedge clk);
    chk("ser_q_drained", ser_q.size(), 0);
    chk("unl_rise_q_drained", unl_rise_q.size(), 0);
    chk("unl_len_q_drained", unl_len_q.size(), 0);
    chk("lock_len_q_drained", lock_len_q.size(), 0);
    chk("fail_q_drained", fail_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/safe_lock_ctrl.md
SAFE_LOCK_CTRL -- requirements
Module: safe_lock_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): UNLOCK_CYCLES, 16, cycles unlocked stays high; LOCKOUT_CYCLES, 64, lockout duration; MAX_FAILS, 3, consecutive failures (1..3) that trigger lockout.
REQ-002 SHALL have one clock and one reset, asynchronous and active-high: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-003 SHALL have code_valid input 1 (entry request); code_data input 4 (code, MSB sent first); code_ready output 1 (controller accepts code).
REQ-004 SHALL have ser_val output 1 and ser_data output 1, the serial bit valid and bit value driven to the unlock mechanism.
REQ-005 SHALL have mech_out_val input 1 and mech_out_data input 1, the unlock mechanism's Moore outputs (val=0 only in its IDLE; data=1 only when the full code has matched).
REQ-006 SHALL have unlocked output 1, lockout output 1, fail_cnt output 2 (consecutive failures) and err output 1 (resync failure).

Function
REQ-007 SHALL implement states FLUSH_CHK, FLUSH_TX, IDLE, SEND, EVAL, UNLOCK, LOCKOUT and ERROR, with all outputs decoded from registered state and registers only.
REQ-008 SHALL, in IDLE, drive code_ready=1 and, on code_valid&&code_ready, capture code_data and enter SEND; code_ready=0 in every other state.
REQ-009 SHALL, in SEND, spend exactly 4 cycles driving ser_val=1 and ser_data=code[3], code[2], code[1], code[0] in order, then enter EVAL; ser_val=0 in all other states except FLUSH_TX.
REQ-010 SHALL, in EVAL (the cycle after the last bit), sample mech_out_data: 1 -> UNLOCK and fail_cnt cleared to 0; 0 -> fail_cnt+1, then LOCKOUT if the new value equals MAX_FAILS, else FLUSH_CHK.
REQ-011 SHALL hold unlocked=1 for exactly UNLOCK_CYCLES cycles in UNLOCK, then enter FLUSH_CHK.
REQ-012 SHALL hold lockout=1 for exactly LOCKOUT_CYCLES cycles in LOCKOUT, clear fail_cnt to 0 on exit, then enter FLUSH_CHK.
REQ-013 SHALL, in FLUSH_CHK, enter IDLE if mech_out_val=0, else enter FLUSH_TX; FLUSH_TX drives ser_val=1, ser_data=0 for one cycle, then returns to FLUSH_CHK.
REQ-014 SHALL count FLUSH_TX visits per flush sequence; a 5th required visit SHALL instead enter ERROR, and the counter SHALL clear on entering IDLE.
REQ-015 SHALL hold ERROR (err=1, all other outputs 0 except fail_cnt) until reset.
REQ-016 SHALL saturate fail_cnt at MAX_FAILS; code_valid outside IDLE SHALL be ignored and never queued.
REQ-017 SHALL size the unlock and lockout timers to $clog2 of the larger parameter plus 1 bit, with no wrap-around before expiry.

Reset
REQ-018 SHALL, on rst assertion and asynchronously, enter FLUSH_CHK and clear the code register, timers, flush counter, fail_cnt, unlocked, lockout, err, ser_val and ser_data to 0; code_ready=0 during reset.
REQ-019 SHALL, on reset mid-SEND or mid-UNLOCK, drop ser_val and unlocked in the same cycle rst asserts and resynchronise the mechanism via the flush sequence after release.

Configuration
REQ-020 SHALL, with macro SAFE_LOCK_ALARM_EN defined, add input alarm_clr (1) and output alarm (1); alarm sets on LOCKOUT entry and stays set through LOCKOUT exit until alarm_clr=1 or rst; alarm_clr has no effect in the cycle alarm sets.
REQ-021 SHALL, without SAFE_LOCK_ALARM_EN, omit both ports and all alarm logic, with behaviour otherwise identical.

Verification
REQ-022 Correct code: code_data=4'b1011 accepted in cycle t -> ser_data 1,0,1,1 in t+1..t+4; unlocked=1 for 16 cycles from t+6; one FLUSH_TX bit; back to IDLE with code_ready=1.
REQ-023 Wrong code: 4'b0011 -> mechanism ends in INCORRECT; EVAL fails; fail_cnt=1; one flush bit; IDLE; unlocked never asserts.
REQ-024 Lockout: three wrong codes -> lockout=1 for 64 cycles with code_ready=0 and code_valid ignored; then fail_cnt=0 and return to IDLE; alarm=1 (macro on) until alarm_clr pulses.
REQ-025 Resync failure: mechanism model holding mech_out_val=1 after reset -> exactly 4 FLUSH_TX bits, then err=1 held until rst.
REQ-026 Reset mid-operation: rst asserted during the 2nd SEND bit -> ser_val=0 immediately; after release, flush sequence drives the mechanism to val=0, then IDLE.
REQ-027 Failure reset by success: two wrong codes, then 4'b1011 -> fail_cnt 1, 2, then 0; no lockout.
